// File: rtl/tap_scheduler.sv
// tap_scheduler: per-sample delay-line tap sequencer.
// Writes the incoming sample at wptr, then reads the main, chorus and reverb
// taps from a 1-cycle-latency RAM, strobing each load as its data arrives.
// The frame is then handed to the MCU and held until transmit is seen.
// Optional feature: define TAP_SCHEDULER_CHORUS_LFO_EN to modulate the chorus
// tap with a triangle LFO; otherwise the chorus offset is CHOR_BASE.
module tap_scheduler #(
  parameter int ADDR_W     = 12,
  parameter int CHOR_BASE  = 600,
  parameter int CHOR_DEPTH = 255,
  parameter int LFO_DIV    = 8,
  parameter int REV_DELAY  = 3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              chorus_on,
  input  logic              reverb_on,
  input  logic              transmit,
  input  logic [15:0]       mem_data,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              main_load,
  output logic              chor_load,
  output logic              rev_load,
  output logic              tfr_ready,
  output logic              busy,
  output logic              overrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RM   = 3'd2;
  localparam logic [2:0] S_RC   = 3'd3;
  localparam logic [2:0] S_RR   = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;
  localparam logic [2:0] S_WAIT = 3'd6;

  localparam logic [ADDR_W-1:0] CHOR_BASE_A = ADDR_W'(CHOR_BASE);
  localparam logic [ADDR_W-1:0] REV_DELAY_A = ADDR_W'(REV_DELAY);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              overrun_q, overrun_d;
  logic [ADDR_W-1:0] chor_off;
  logic              frame_done;

  // Sample data flows straight to the downstream datapath; the scheduler only
  // times the strobes, so the read data is not consumed here.
  logic mem_data_unused;
  assign mem_data_unused = ^mem_data;

  assign frame_done = (state_q == S_WAIT) && transmit;

`ifdef TAP_SCHEDULER_CHORUS_LFO_EN
  localparam int                DIV_W    = (LFO_DIV > 1) ? $clog2(LFO_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(LFO_DIV - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(CHOR_DEPTH);

  logic [ADDR_W-1:0] lfo_q, lfo_d;
  logic              lfo_up_q, lfo_up_d;
  logic [DIV_W-1:0]  lfo_div_q, lfo_div_d;

  assign chor_off = CHOR_BASE_A + lfo_q;

  // Triangle LFO: one step every LFO_DIV completed frames, bouncing off both ends.
  always_comb begin
    lfo_d     = lfo_q;
    lfo_up_d  = lfo_up_q;
    lfo_div_d = lfo_div_q;
    if (frame_done) begin
      if (lfo_div_q == DIV_LAST) begin
        lfo_div_d = '0;
        if (lfo_up_q) begin
          if (lfo_q >= DEPTH_A) begin
            lfo_d    = lfo_q - 1'b1;
            lfo_up_d = 1'b0;
          end else begin
            lfo_d = lfo_q + 1'b1;
          end
        end else begin
          if (lfo_q == '0) begin
            lfo_d    = lfo_q + 1'b1;
            lfo_up_d = 1'b1;
          end else begin
            lfo_d = lfo_q - 1'b1;
          end
        end
      end else begin
        lfo_div_d = lfo_div_q + 1'b1;
      end
    end
  end

  // LFO state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfo_q     <= '0;
      lfo_up_q  <= 1'b1;
      lfo_div_q <= '0;
    end else begin
      lfo_q     <= lfo_d;
      lfo_up_q  <= lfo_up_d;
      lfo_div_q <= lfo_div_d;
    end
  end
`else
  assign chor_off = CHOR_BASE_A;
`endif

  // Sequence control: fixed-length tap walk, write pointer advance, overrun capture.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    overrun_d = overrun_q | (start && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: if (start) state_d = S_WR;
      S_WR:   state_d = S_RM;
      S_RM:   state_d = S_RC;
      S_RC:   state_d = S_RR;
      S_RR:   state_d = S_FIN;
      S_FIN:  state_d = S_WAIT;
      S_WAIT: begin
        if (transmit) begin
          state_d = S_IDLE;
          wptr_d  = wptr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      overrun_q <= overrun_d;
    end
  end

  // Output decode: address for each tap one cycle ahead of its load strobe.
  always_comb begin
    mem_write = 1'b0;
    mem_addr  = '0;
    main_load = 1'b0;
    chor_load = 1'b0;
    rev_load  = 1'b0;
    case (state_q)
      S_WR: begin
        mem_write = 1'b1;
        mem_addr  = wptr_q;
      end
      S_RM: mem_addr = wptr_q;
      S_RC: begin
        mem_addr  = wptr_q - chor_off;
        main_load = 1'b1;
      end
      S_RR: begin
        mem_addr  = wptr_q - REV_DELAY_A;
        chor_load = chorus_on;
      end
      S_FIN: rev_load = reverb_on;
      default: ;
    endcase
  end

  assign tfr_ready = (state_q == S_WAIT);
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: doc/tap_scheduler.md
TAP_SCHEDULER -- requirements
Module: tap_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: sample memory address width; ring depth is 2^ADDR_W words.
REQ-002 SHALL have parameter CHOR_BASE, default 600: chorus tap base delay, in samples.
REQ-003 SHALL have parameter CHOR_DEPTH, default 255: chorus LFO peak excursion, in samples.
REQ-004 SHALL have parameter LFO_DIV, default 8: samples per chorus LFO step.
REQ-005 SHALL have parameter REV_DELAY, default 3000: reverb tap delay, in samples.
REQ-006 SHALL have ports, one per line:
- clk  in  1  single block clock (fpga_sck domain).
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle sample-begin pulse.
- chorus_on  in  1  enables the chorus load strobe.
- reverb_on  in  1  enables the reverb load strobe.
- transmit  in  1  MCU transfer-complete acknowledge.
- mem_data  in  16  synchronous RAM read data.
- mem_write  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- main_load  out  1  one-cycle strobe; mem_data holds the current sample.
- chor_load  out  1  one-cycle strobe; mem_data holds the chorus tap.
- rev_load  out  1  one-cycle strobe; mem_data holds the reverb tap.
- tfr_ready  out  1  frame ready for MCU.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky dropped-start flag.

Function
REQ-007 SHALL implement the FSM IDLE->WR->RM->RC->RR->FIN->WAIT->IDLE, advancing one state per clk except at IDLE and WAIT.
REQ-008 In IDLE, a start pulse SHALL move the FSM to WR on the next edge; otherwise it SHALL hold in IDLE.
REQ-009 WR SHALL drive mem_write=1 and mem_addr=wptr; mem_write SHALL be 0 in every other state.
REQ-010 RM SHALL drive mem_addr=wptr.
REQ-011 RC SHALL drive mem_addr=wptr-chor_off and main_load=1.
REQ-012 RR SHALL drive mem_addr=wptr-REV_DELAY and chor_load=chorus_on.
REQ-013 FIN SHALL drive rev_load=reverb_on.
REQ-014 RAM read latency is 1 cycle, so each load strobe SHALL coincide with valid mem_data for its tap.
REQ-015 The timing of the sequence SHALL NOT vary with chorus_on or reverb_on; disabled taps SHALL still be addressed, with their strobe held low.
REQ-016 WAIT SHALL hold tfr_ready=1 until transmit=1; on that edge the FSM SHALL go to IDLE and wptr SHALL increment.
REQ-017 tfr_ready SHALL be 0 in all states other than WAIT.
REQ-018 transmit outside WAIT SHALL be ignored.
REQ-019 All address arithmetic SHALL be modulo 2^ADDR_W; wptr SHALL wrap 2^ADDR_W-1 -> 0, and wptr-offset SHALL wrap below 0.
REQ-020 A start pulse while busy=1 SHALL be dropped and SHALL set overrun; this includes a start in the same cycle as the accepted transmit in WAIT.
REQ-021 overrun SHALL clear only on reset.
REQ-022 Every load strobe SHALL be asserted for exactly one cycle per frame, at most.

Reset
REQ-023 While reset=0, the block SHALL asynchronously force the FSM to IDLE, wptr=0, LFO count=0, LFO direction=up, and the LFO divider=0.
REQ-024 While reset=0, all outputs SHALL be 0, including mem_addr=0 and overrun=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no write, strobe or wptr increment after the reset edge.
REQ-026 Release SHALL be synchronous to clk, and the first start after release SHALL be accepted.

Configuration
REQ-027 Macro TAP_SCHEDULER_CHORUS_LFO_EN SHALL select the chorus modulation.
REQ-028 With the macro defined: chor_off=CHOR_BASE+lfo.
- lfo is a triangle counter over 0..CHOR_DEPTH.
- It steps by +/-1 once every LFO_DIV completed frames (counted on wptr increments).
- Direction reverses at 0 and at CHOR_DEPTH, with no hold at either endpoint.
REQ-029 Without the macro: chor_off=CHOR_BASE constant, and no LFO registers exist.

Verification
REQ-030 Reset, then start at wptr=0 -> mem_write at cycle 1 with addr 0, main_load at cycle 3, chor_load at cycle 4 with addr 4096-600=3496, rev_load at cycle 5 with addr 1096, tfr_ready from cycle 6.
REQ-031 Run 4096 frames -> wptr wraps to 0; the frame after the wrap writes addr 0 and reads the reverb tap at addr 1096.
REQ-032 Pulse start during RC -> the start is ignored and overrun=1; after transmit the FSM returns to IDLE and overrun stays 1.
REQ-033 chorus_on=0, reverb_on=1 -> chor_load is never high, rev_load is high once per frame, and frame timing is unchanged.
REQ-034 Assert reset during RR -> the FSM is IDLE immediately, all outputs are 0, and the next start performs its write at addr 0.
REQ-035 With TAP_SCHEDULER_CHORUS_LFO_EN defined, LFO_DIV=1, CHOR_DEPTH=3 -> successive frames use chorus offsets 600, 601, 602, 603, 602, 601, 600, 601.
